ps2_mouse_ctrl: RTL and testbench

//  Host-side PS/2 mouse controller, directly upstream of ps2_tx; consumes bytes from the PS/2 receiver.

---
 rtl/ps2_mouse_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl.sv
// Host-side PS/2 mouse controller: runs the reset/enable init handshake
// through the ps2_tx byte interface, then assembles 3-byte stream packets.
module ps2_mouse_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int PKT_GAP_CYCLES = 1_000_000
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    output logic       tx_wr_en,
    output logic [7:0] tx_wr_data,
    input  logic       tx_wr_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] retry_cnt,
    output logic       pkt_valid,
    output logic [7:0] pkt_status,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(PKT_GAP_CYCLES + 1);
    localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(PKT_GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        SEND_RST, WAIT_TXD_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID,
        SEND_EN, WAIT_TXD_EN, WAIT_ACK2, STREAM, ERROR
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tmo_cnt;
    logic          waiting, expect_chk, fail, tx_req, retry_inc;
    logic [7:0]    expect_byte, tx_byte;

    logic [1:0]    byte_idx, idx_eff;
    logic [GW-1:0] gap_cnt;
    logic          gap_exp;
    logic [7:0]    status_r, dx_r;

    // Next-state logic: handshake progression plus common failure/retry handling
    always_comb begin
        state_next  = state;
        tx_req      = 1'b0;
        tx_byte     = 8'h00;
        waiting     = 1'b0;
        expect_chk  = 1'b0;
        expect_byte = 8'h00;
        fail        = 1'b0;
        retry_inc   = 1'b0;
        case (state)
            SEND_RST: begin
                tx_req     = 1'b1;
                tx_byte    = 8'hFF;
                state_next = WAIT_TXD_RST;
            end
            WAIT_TXD_RST: begin
                waiting = 1'b1;
                if (tx_wr_done) state_next = WAIT_ACK1;
            end
            WAIT_ACK1: begin
                waiting = 1'b1; expect_chk = 1'b1; expect_byte = 8'hFA;
                if (rx_valid && rx_data == 8'hFA) state_next = WAIT_BAT;
            end
            WAIT_BAT: begin
                waiting = 1'b1; expect_chk = 1'b1; expect_byte = 8'hAA;
                if (rx_valid && rx_data == 8'hAA) state_next = WAIT_ID;
            end
            WAIT_ID: begin
                waiting = 1'b1; expect_chk = 1'b1; expect_byte = 8'h00;
                if (rx_valid && rx_data == 8'h00) state_next = SEND_EN;
            end
            SEND_EN: begin
                tx_req     = 1'b1;
                tx_byte    = 8'hF4;
                state_next = WAIT_TXD_EN;
            end
            WAIT_TXD_EN: begin
                waiting = 1'b1;
                if (tx_wr_done) state_next = WAIT_ACK2;
            end
            WAIT_ACK2: begin
                waiting = 1'b1; expect_chk = 1'b1; expect_byte = 8'hFA;
                if (rx_valid && rx_data == 8'hFA) state_next = STREAM;
            end
            default: state_next = state;   // STREAM and ERROR are terminal
        endcase
        // A failure overrides any advance taken in the same cycle
        fail = (waiting && tmo_cnt == TMO_LAST) ||
               (expect_chk && rx_valid && rx_data != expect_byte);
        if (fail) begin
            if (retry_cnt < RETRY_LIM) begin
                retry_inc  = 1'b1;
                state_next = SEND_RST;
            end else begin
                state_next = ERROR;
            end
        end
    end

    // State register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= SEND_RST;
        else        state <= state_next;
    end

    // Per-state timeout: restarts on every state entry, runs only while waiting
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)                   tmo_cnt <= '0;
        else if (state_next != state) tmo_cnt <= '0;
        else if (waiting)             tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Registered control outputs; tx_wr_data holds until the next request
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_en   <= 1'b0;
            tx_wr_data <= 8'h00;
            retry_cnt  <= 2'd0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            tx_wr_en <= tx_req;
            if (tx_req)              tx_wr_data <= tx_byte;
            if (retry_inc)           retry_cnt  <= retry_cnt + 2'd1;
            if (state_next == STREAM) init_done  <= 1'b1;
            if (state_next == ERROR)  init_error <= 1'b1;
        end
    end

    // A byte arriving on the gap-expiry cycle starts a new packet
    assign gap_exp = (byte_idx != 2'd0) && (gap_cnt == GAP_LAST);
    assign idx_eff = gap_exp ? 2'd0 : byte_idx;

    // Stream packet assembly with sync on status bit 3 and inter-byte gap resync
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            gap_cnt    <= '0;
            status_r   <= 8'h00;
            dx_r       <= 8'h00;
            pkt_valid  <= 1'b0;
            pkt_status <= 8'h00;
            pkt_dx     <= 9'h000;
            pkt_dy     <= 9'h000;
        end else begin
            pkt_valid <= 1'b0;
            if (state == STREAM) begin
                if (rx_valid) begin
                    gap_cnt <= '0;
                    case (idx_eff)
                        2'd0: begin
                            if (rx_data[3]) begin
                                status_r <= rx_data;
                                byte_idx <= 2'd1;
                            end else begin
                                byte_idx <= 2'd0;
                            end
                        end
                        2'd1: begin
                            dx_r     <= rx_data;
                            byte_idx <= 2'd2;
                        end
                        default: begin
                            pkt_status <= status_r;
                            pkt_dx     <= {status_r[4], dx_r};
                            pkt_dy     <= {status_r[5], rx_data};
                            pkt_valid  <= 1'b1;
                            byte_idx   <= 2'd0;
                        end
                    endcase
                end else if (gap_exp) begin
                    byte_idx <= 2'd0;
                    gap_cnt  <= '0;
                end else if (byte_idx != 2'd0) begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: a small ps2_tx/mouse model answers the
// init handshake; stream packets are injected byte by byte.
module tb_ps2_mouse_ctrl;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic       tx_wr_done = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       init_done, init_error;
    logic [1:0] retry_cnt;
    logic       pkt_valid;
    logic [7:0] pkt_status;
    logic [8:0] pkt_dx, pkt_dy;

    ps2_mouse_ctrl #(
        .TIMEOUT_CYCLES(1000),
        .MAX_RETRY(2),
        .PKT_GAP_CYCLES(500)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_wr_done(tx_wr_done),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .init_done(init_done), .init_error(init_error), .retry_cnt(retry_cnt),
        .pkt_valid(pkt_valid), .pkt_status(pkt_status), .pkt_dx(pkt_dx), .pkt_dy(pkt_dy)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Device model state
    logic [7:0] tx_log[$];
    logic [7:0] rsp_q[$];
    logic [7:0] pend;
    int done_cd = -1;
    int rsp_gap = 0;
    bit silent = 0;
    int nack_left = 0;

    // Packet monitor
    int pkt_cnt = 0;
    logic [7:0] last_st;
    logic [8:0] last_dx, last_dy;

    always @(negedge clk_sys) begin
        if (pkt_valid === 1'b1) begin
            pkt_cnt++;
            last_st = pkt_status;
            last_dx = pkt_dx;
            last_dy = pkt_dy;
        end
    end

    function automatic logic [23:0] log_seq();
        logic [23:0] s = '0;
        foreach (tx_log[i]) s = {s[15:0], tx_log[i]};
        return s;
    endfunction

    // One cycle of the ps2_tx + mouse model
    task automatic step();
        @(negedge clk_sys);
        tx_wr_done = 1'b0;
        rx_valid   = 1'b0;
        if (tx_wr_en === 1'b1) begin
            tx_log.push_back(tx_wr_data);
            pend    = tx_wr_data;
            done_cd = 10;
        end else if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
                tx_wr_done = 1'b1;
                done_cd    = -1;
                rsp_gap    = 5;
                if (!silent) begin
                    if (pend == 8'hFF) begin
                        if (nack_left > 0) begin
                            rsp_q.push_back(8'hFE);
                            nack_left--;
                        end else begin
                            rsp_q.push_back(8'hFA);
                            rsp_q.push_back(8'hAA);
                            rsp_q.push_back(8'h00);
                        end
                    end else if (pend == 8'hF4) begin
                        rsp_q.push_back(8'hFA);
                    end
                end
            end
        end else if (rsp_q.size() > 0) begin
            if (rsp_gap > 0) rsp_gap--;
            else begin
                rx_valid = 1'b1;
                rx_data  = rsp_q.pop_front();
                rsp_gap  = 5;
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tx_wr_done = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        repeat (3) @(negedge clk_sys);
        tx_log.delete();
        rsp_q.delete();
        done_cd = -1;
        rsp_gap = 0;
        rst_n   = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk_sys);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if ({tx_wr_en, tx_wr_data, init_done, init_error, retry_cnt, pkt_valid,
             pkt_status, pkt_dx, pkt_dy} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got tx_en=%b data=%h done=%b err=%b retry=%0d pv=%b st=%h dx=%h dy=%h expected all 0",
                     tx_wr_en, tx_wr_data, init_done, init_error, retry_cnt, pkt_valid, pkt_status, pkt_dx, pkt_dy);
        end
        do_reset();
        step();
        checks++;
        if (tx_log.size() != 1 || log_seq() !== 24'h0000FF) begin
            errors++;
            $display("FAIL reset_first_tx: got n=%0d seq=%h expected n=1 seq=0000ff", tx_log.size(), log_seq());
        end
    endtask

    task automatic test_nominal();
        int n;
        silent = 0; nack_left = 0;
        do_reset();
        n = 0;
        while (init_done !== 1'b1 && n < 3000) begin step(); n++; end
        checks++;
        if (init_done !== 1'b1 || init_error !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done: got done=%b err=%b expected done=1 err=0", init_done, init_error);
        end
        checks++;
        if (tx_log.size() != 2 || log_seq() !== 24'h00FFF4) begin
            errors++;
            $display("FAIL nominal_tx_seq: got n=%0d seq=%h expected n=2 seq=00fff4", tx_log.size(), log_seq());
        end
        checks++;
        if (retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL nominal_retry: got %0d expected 0", retry_cnt);
        end
        repeat (100) step();
        checks++;
        if (tx_log.size() != 2) begin
            errors++;
            $display("FAIL stream_no_tx: got n=%0d expected 2", tx_log.size());
        end
    endtask

    task automatic test_packet();
        int c0;
        c0 = pkt_cnt;
        send_byte(8'h28); send_byte(8'h05); send_byte(8'hF0);
        repeat (3) @(negedge clk_sys);
        checks++;
        if (pkt_cnt - c0 != 1) begin
            errors++;
            $display("FAIL packet_count: got %0d expected 1", pkt_cnt - c0);
        end
        checks++;
        if ({last_st, last_dx, last_dy} !== {8'h28, 9'h005, 9'h1F0}) begin
            errors++;
            $display("FAIL packet_fields: got st=%h dx=%h dy=%h expected st=28 dx=005 dy=1f0", last_st, last_dx, last_dy);
        end
    endtask

    task automatic test_resync();
        int c0;
        c0 = pkt_cnt;
        send_byte(8'h05); send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
        repeat (3) @(negedge clk_sys);
        checks++;
        if (pkt_cnt - c0 != 1 || {last_st, last_dx, last_dy} !== {8'h08, 9'h001, 9'h002}) begin
            errors++;
            $display("FAIL sync_discard: got n=%0d st=%h dx=%h dy=%h expected n=1 st=08 dx=001 dy=002",
                     pkt_cnt - c0, last_st, last_dx, last_dy);
        end
        c0 = pkt_cnt;
        send_byte(8'h08); send_byte(8'h01);
        repeat (600) @(negedge clk_sys);
        send_byte(8'h09); send_byte(8'h00); send_byte(8'h00);
        repeat (3) @(negedge clk_sys);
        checks++;
        if (pkt_cnt - c0 != 1) begin
            errors++;
            $display("FAIL gap_count: got %0d expected 1", pkt_cnt - c0);
        end
        checks++;
        if ({last_st, last_dx, last_dy} !== {8'h09, 9'h000, 9'h000}) begin
            errors++;
            $display("FAIL gap_fields: got st=%h dx=%h dy=%h expected st=09 dx=000 dy=000", last_st, last_dx, last_dy);
        end
    endtask

    task automatic test_nack();
        int n;
        silent = 0; nack_left = 1;
        do_reset();
        n = 0;
        while (init_done !== 1'b1 && init_error !== 1'b1 && n < 5000) begin step(); n++; end
        checks++;
        if (init_done !== 1'b1 || retry_cnt !== 2'd1) begin
            errors++;
            $display("FAIL nack_result: got done=%b retry=%0d expected done=1 retry=1", init_done, retry_cnt);
        end
        checks++;
        if (tx_log.size() != 3 || log_seq() !== 24'hFFFFF4) begin
            errors++;
            $display("FAIL nack_tx_seq: got n=%0d seq=%h expected n=3 seq=fffff4", tx_log.size(), log_seq());
        end
    endtask

    task automatic test_timeout();
        int n;
        silent = 1; nack_left = 0;
        do_reset();
        n = 0;
        while (init_error !== 1'b1 && n < 6000) begin step(); n++; end
        checks++;
        if (init_error !== 1'b1 || init_done !== 1'b0 || retry_cnt !== 2'd2) begin
            errors++;
            $display("FAIL timeout_result: got err=%b done=%b retry=%0d expected err=1 done=0 retry=2",
                     init_error, init_done, retry_cnt);
        end
        checks++;
        if (n < 3000) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected at least 3000", n);
        end
        checks++;
        if (tx_log.size() != 3 || log_seq() !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL timeout_tx_seq: got n=%0d seq=%h expected n=3 seq=ffffff", tx_log.size(), log_seq());
        end
        repeat (200) step();
        checks++;
        if (tx_log.size() != 3) begin
            errors++;
            $display("FAIL error_no_tx: got n=%0d expected 3", tx_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        silent = 1; nack_left = 0;
        do_reset();
        repeat (15) step();           // 0xFF sent and acknowledged by ps2_tx
        rsp_q.push_back(8'hFE);       // force one retry
        repeat (30) step();
        rsp_q.push_back(8'hFA);       // now parked in WAIT_BAT
        repeat (10) step();
        checks++;
        if (retry_cnt !== 2'd1 || tx_log.size() != 2) begin
            errors++;
            $display("FAIL mid_pre_state: got retry=%0d n=%0d expected retry=1 n=2", retry_cnt, tx_log.size());
        end
        @(negedge clk_sys);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_wr_en, tx_wr_data, init_done, init_error, retry_cnt, pkt_valid} !== 14'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got tx_en=%b data=%h done=%b err=%b retry=%0d expected all 0",
                     tx_wr_en, tx_wr_data, init_done, init_error, retry_cnt);
        end
        do_reset();
        silent = 0;
        step();
        checks++;
        if (tx_log.size() != 1 || log_seq() !== 24'h0000FF) begin
            errors++;
            $display("FAIL mid_first_tx: got n=%0d seq=%h expected n=1 seq=0000ff", tx_log.size(), log_seq());
        end
        n = 0;
        while (init_done !== 1'b1 && n < 3000) begin step(); n++; end
        checks++;
        if (init_done !== 1'b1 || retry_cnt !== 2'd0 || log_seq() !== 24'h00FFF4) begin
            errors++;
            $display("FAIL mid_reinit: got done=%b retry=%0d seq=%h expected done=1 retry=0 seq=00fff4",
                     init_done, retry_cnt, log_seq());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_packet();
        test_resync();
        test_nack();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
